// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle RV32I-subset control FSM with memory handshake and timeout trap
module mc_ctrl #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        alu_f,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        ram_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  npc_op,
   output logic        rf_we,
   output logic [1:0]  wd_sel,
   output logic [2:0]  sext_op,
   output logic [3:0]  alu_op,
   output logic        alub_sel,
   output logic        trap,
   output logic [1:0]  trap_cause
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
   typedef enum logic [3:0] {C_R, C_I, C_LW, C_SW, C_BR, C_LUI, C_JAL, C_JALR, C_ILL} cls_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;
   logic        timeout;
   logic [1:0]  cause_q;

   cls_t        cls;
   logic [3:0]  dec_alu;
   logic        dec_sel;
   logic [2:0]  dec_sext;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        f7_zero;
   logic        f7_alt;
   logic        unused_inst;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign funct7      = inst[31:25];
   assign f7_zero     = (funct7 == 7'b0000000);
   assign f7_alt      = (funct7 == 7'b0100000);
   assign unused_inst = ^{inst[24:15], inst[11:7]};

   always_comb begin
      cls      = C_ILL;
      dec_alu  = 4'd0;
      dec_sel  = 1'b0;
      dec_sext = 3'd0;
      case (opcode)
         7'b0110011: begin
            case (funct3)
               3'b000: if (f7_zero || f7_alt) begin cls = C_R; dec_alu = f7_alt ? 4'd1 : 4'd0; end
               3'b001: if (f7_zero) begin cls = C_R; dec_alu = 4'd5; end
               3'b100: if (f7_zero) begin cls = C_R; dec_alu = 4'd4; end
               3'b101: if (f7_zero || f7_alt) begin cls = C_R; dec_alu = f7_alt ? 4'd7 : 4'd6; end
               3'b110: if (f7_zero) begin cls = C_R; dec_alu = 4'd3; end
               3'b111: if (f7_zero) begin cls = C_R; dec_alu = 4'd2; end
               default: cls = C_ILL;
            endcase
         end
         7'b0010011: begin
            dec_sel = 1'b1;
            // Only shift-immediates carry funct7; arithmetic immediates use the full 12 bits
            case (funct3)
               3'b000: begin cls = C_I; dec_alu = 4'd0; end
               3'b100: begin cls = C_I; dec_alu = 4'd4; end
               3'b110: begin cls = C_I; dec_alu = 4'd3; end
               3'b111: begin cls = C_I; dec_alu = 4'd2; end
               3'b001: if (f7_zero) begin cls = C_I; dec_alu = 4'd5; end
               3'b101: if (f7_zero || f7_alt) begin cls = C_I; dec_alu = f7_alt ? 4'd7 : 4'd6; end
               default: cls = C_ILL;
            endcase
         end
         7'b0000011: begin
            dec_sel = 1'b1;
            if (funct3 == 3'b010) cls = C_LW;
         end
         7'b0100011: begin
            dec_sel  = 1'b1;
            dec_sext = 3'd1;
            if (funct3 == 3'b010) cls = C_SW;
         end
         7'b1100011: begin
            dec_sext = 3'd2;
            case (funct3)
               3'b000: begin cls = C_BR; dec_alu = 4'd9;  end
               3'b001: begin cls = C_BR; dec_alu = 4'd10; end
               3'b100: begin cls = C_BR; dec_alu = 4'd11; end
               3'b101: begin cls = C_BR; dec_alu = 4'd12; end
               default: cls = C_ILL;
            endcase
         end
         7'b0110111: begin cls = C_LUI; dec_alu = 4'd8; dec_sel = 1'b1; dec_sext = 3'd3; end
         7'b1101111: begin cls = C_JAL; dec_sel = 1'b1; dec_sext = 3'd4; end
         7'b1100111: begin
            dec_sel = 1'b1;
            if (funct3 == 3'b000) cls = C_JALR;
         end
         default: cls = C_ILL;
      endcase
   end

   // Counter saturates at MAX_WAIT; the trap fires on the cycle it would get there
   assign wait_nxt = (wait_cnt == MAX_W) ? MAX_W : wait_cnt + 8'd1;
   assign timeout  = (wait_nxt == MAX_W);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         wait_cnt <= 8'd0;
         cause_q  <= 2'd0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  state    <= S_DECODE;
                  wait_cnt <= 8'd0;
               end else if (timeout) begin
                  state    <= S_TRAP;
                  cause_q  <= 2'd2;
                  wait_cnt <= 8'd0;
               end else begin
                  wait_cnt <= wait_nxt;
               end
            end
            S_DECODE: begin
               wait_cnt <= 8'd0;
               if (cls == C_ILL) begin
                  state   <= S_TRAP;
                  cause_q <= 2'd1;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               wait_cnt <= 8'd0;
               if (cls == C_BR)                      state <= S_FETCH;
               else if (cls == C_LW || cls == C_SW)  state <= S_MEM;
               else                                  state <= S_WB;
            end
            S_MEM: begin
               if (mem_ready) begin
                  state    <= (cls == C_SW) ? S_FETCH : S_WB;
                  wait_cnt <= 8'd0;
               end else if (timeout) begin
                  state    <= S_TRAP;
                  cause_q  <= 2'd2;
                  wait_cnt <= 8'd0;
               end else begin
                  wait_cnt <= wait_nxt;
               end
            end
            S_WB: begin
               state    <= S_FETCH;
               wait_cnt <= 8'd0;
            end
            S_TRAP: wait_cnt <= 8'd0;
            default: begin
               state    <= S_FETCH;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   logic        mem_req_c, ram_we_c, ir_we_c, pc_we_c, rf_we_c, alub_sel_c, trap_c;
   logic [1:0]  npc_op_c, wd_sel_c;
   logic [2:0]  sext_op_c;
   logic [3:0]  alu_op_c;

   always_comb begin
      mem_req_c  = 1'b0;
      ram_we_c   = 1'b0;
      ir_we_c    = 1'b0;
      pc_we_c    = 1'b0;
      npc_op_c   = 2'd0;
      rf_we_c    = 1'b0;
      wd_sel_c   = 2'd0;
      sext_op_c  = 3'd0;
      alu_op_c   = 4'd0;
      alub_sel_c = 1'b0;
      trap_c     = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req_c = 1'b1;
            ir_we_c   = mem_ready;
         end
         S_DECODE: sext_op_c = dec_sext;
         S_EXEC: begin
            sext_op_c  = dec_sext;
            alu_op_c   = dec_alu;
            alub_sel_c = dec_sel;
            // alu_f only reaches pc logic for branches, where alu_op is a compare
            if (cls == C_BR) begin
               pc_we_c  = 1'b1;
               npc_op_c = alu_f ? 2'd1 : 2'd0;
            end
         end
         S_MEM: begin
            sext_op_c  = dec_sext;
            alu_op_c   = dec_alu;
            alub_sel_c = dec_sel;
            mem_req_c  = 1'b1;
            ram_we_c   = (cls == C_SW);
            pc_we_c    = mem_ready && (cls == C_SW);
         end
         S_WB: begin
            sext_op_c  = dec_sext;
            alu_op_c   = dec_alu;
            alub_sel_c = dec_sel;
            rf_we_c    = 1'b1;
            pc_we_c    = 1'b1;
            if (cls == C_LW)                          wd_sel_c = 2'd1;
            else if (cls == C_JAL || cls == C_JALR)   wd_sel_c = 2'd2;
            if (cls == C_JAL)       npc_op_c = 2'd1;
            else if (cls == C_JALR) npc_op_c = 2'd2;
         end
         S_TRAP: trap_c = 1'b1;
         default: trap_c = 1'b0;
      endcase
   end

   assign mem_req    = rst_n & mem_req_c;
   assign ram_we     = rst_n & ram_we_c;
   assign ir_we      = rst_n & ir_we_c;
   assign pc_we      = rst_n & pc_we_c;
   assign npc_op     = rst_n ? npc_op_c : 2'd0;
   assign rf_we      = rst_n & rf_we_c;
   assign wd_sel     = rst_n ? wd_sel_c : 2'd0;
   assign sext_op    = rst_n ? sext_op_c : 3'd0;
   assign alu_op     = rst_n ? alu_op_c : 4'd0;
   assign alub_sel   = rst_n & alub_sel_c;
   assign trap       = rst_n & trap_c;
   assign trap_cause = rst_n ? cause_q : 2'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl, per-cycle output vectors
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inst = 32'd0;
   logic        alu_f = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, ram_we, ir_we, pc_we, rf_we, alub_sel, trap;
   logic [1:0]  npc_op, wd_sel, trap_cause;
   logic [2:0]  sext_op;
   logic [3:0]  alu_op;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic        rn;
      logic        mr;
      logic        af;
      logic [31:0] ins;
   } stim_t;

   stim_t       stim_q[$];
   logic [19:0] exp_q[$];

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_LW   = 32'h0000A183;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_SLT  = 32'h0020A1B3;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_JALR = 32'h000080E7;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_SLLI_BAD = 32'h40209093;

   mc_ctrl #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .alu_f(alu_f), .mem_ready(mem_ready),
      .mem_req(mem_req), .ram_we(ram_we), .ir_we(ir_we), .pc_we(pc_we), .npc_op(npc_op),
      .rf_we(rf_we), .wd_sel(wd_sel), .sext_op(sext_op), .alu_op(alu_op),
      .alub_sel(alub_sel), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   // {mem_req, ram_we, ir_we, pc_we, npc_op, rf_we, wd_sel, sext_op, alu_op, alub_sel, trap, trap_cause}
   function automatic logic [19:0] row(input logic req, input logic we, input logic ir, input logic pc,
                                       input logic [1:0] npc, input logic rf, input logic [1:0] wd,
                                       input logic [2:0] sx, input logic [3:0] op, input logic sel,
                                       input logic tr, input logic [1:0] tc);
      return {req, we, ir, pc, npc, rf, wd, sx, op, sel, tr, tc};
   endfunction

   localparam logic [19:0] ZERO = 20'd0;
   localparam logic [19:0] F_RDY = {1'b1, 1'b0, 1'b1, 17'd0};
   localparam logic [19:0] F_WAIT = {1'b1, 19'd0};

   task automatic push(input logic rn, input logic mr, input logic af, input logic [31:0] ins,
                       input logic [19:0] e);
      stim_t s;
      s.rn = rn; s.mr = mr; s.af = af; s.ins = ins;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic cyc(input stim_t s, output logic [19:0] obs);
      @(negedge clk);
      rst_n = s.rn; mem_ready = s.mr; alu_f = s.af; inst = s.ins;
      #1;
      obs = {mem_req, ram_we, ir_we, pc_we, npc_op, rf_we, wd_sel, sext_op, alu_op,
             alub_sel, trap, trap_cause};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b0; alu_f = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      stim_t s; logic [19:0] e, obs; int k = 0;
      push(0, 1, 1, I_ADD, ZERO);
      push(0, 1, 1, I_ADD, ZERO);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL reset cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_add();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      push(1, 1, 1, I_ADD, F_RDY);
      push(1, 1, 1, I_ADD, ZERO);
      push(1, 1, 1, I_ADD, ZERO);
      push(1, 1, 1, I_ADD, row(0,0,0,1,2'd0,1,2'd0,3'd0,4'd0,0,0,2'd0));
      push(1, 0, 1, I_ADD, F_WAIT);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL add cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_branch();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      push(1, 1, 0, I_BEQ, F_RDY);
      push(1, 1, 0, I_BEQ, row(0,0,0,0,2'd0,0,2'd0,3'd2,4'd0,0,0,2'd0));
      push(1, 1, 1, I_BEQ, row(0,0,0,1,2'd1,0,2'd0,3'd2,4'd9,0,0,2'd0));
      push(1, 1, 1, I_BEQ, F_RDY);
      push(1, 1, 0, I_BEQ, row(0,0,0,0,2'd0,0,2'd0,3'd2,4'd0,0,0,2'd0));
      push(1, 1, 0, I_BEQ, row(0,0,0,1,2'd0,0,2'd0,3'd2,4'd9,0,0,2'd0));
      push(1, 0, 0, I_BEQ, F_WAIT);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL branch cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_lw_wait();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      push(1, 1, 0, I_LW, F_RDY);
      push(1, 1, 0, I_LW, ZERO);
      push(1, 1, 0, I_LW, row(0,0,0,0,2'd0,0,2'd0,3'd0,4'd0,1,0,2'd0));
      for (int i = 0; i < 3; i++)
         push(1, 0, 0, I_LW, row(1,0,0,0,2'd0,0,2'd0,3'd0,4'd0,1,0,2'd0));
      push(1, 1, 0, I_LW, row(1,0,0,0,2'd0,0,2'd0,3'd0,4'd0,1,0,2'd0));
      push(1, 0, 0, I_LW, row(0,0,0,1,2'd0,1,2'd1,3'd0,4'd0,1,0,2'd0));
      push(1, 0, 0, I_LW, F_WAIT);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL lw_wait cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_illegal();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      push(1, 1, 0, I_SLT, F_RDY);
      push(1, 1, 0, I_SLT, ZERO);
      push(1, 1, 0, I_SLT, row(0,0,0,0,2'd0,0,2'd0,3'd0,4'd0,0,1,2'd1));
      push(1, 1, 1, I_SLT, row(0,0,0,0,2'd0,0,2'd0,3'd0,4'd0,0,1,2'd1));
      push(0, 1, 0, I_SLT, ZERO);
      push(1, 0, 0, I_SLT, F_WAIT);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL illegal cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_timeout();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      for (int i = 0; i < 4; i++) push(1, 0, 0, I_ADD, F_WAIT);
      push(1, 0, 0, I_ADD, row(0,0,0,0,2'd0,0,2'd0,3'd0,4'd0,0,1,2'd2));
      push(1, 1, 0, I_ADD, row(0,0,0,0,2'd0,0,2'd0,3'd0,4'd0,0,1,2'd2));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL timeout cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_timeout_race();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      for (int i = 0; i < 3; i++) push(1, 0, 0, I_LUI, F_WAIT);
      push(1, 1, 0, I_LUI, F_RDY);
      push(1, 0, 0, I_LUI, row(0,0,0,0,2'd0,0,2'd0,3'd3,4'd0,0,0,2'd0));
      push(1, 0, 0, I_LUI, row(0,0,0,0,2'd0,0,2'd0,3'd3,4'd8,1,0,2'd0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL timeout_race cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_sw_reset();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      push(1, 1, 0, I_SW, F_RDY);
      push(1, 1, 0, I_SW, row(0,0,0,0,2'd0,0,2'd0,3'd1,4'd0,0,0,2'd0));
      push(1, 1, 0, I_SW, row(0,0,0,0,2'd0,0,2'd0,3'd1,4'd0,1,0,2'd0));
      push(1, 0, 0, I_SW, row(1,1,0,0,2'd0,0,2'd0,3'd1,4'd0,1,0,2'd0));
      push(0, 0, 0, I_SW, ZERO);
      push(0, 1, 1, I_SW, ZERO);
      push(1, 0, 0, I_SW, F_WAIT);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL sw_reset cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s; logic [19:0] e, obs; int k = 0;
      do_reset();
      push(1, 1, 0, I_JAL, F_RDY);
      push(1, 1, 0, I_JAL, row(0,0,0,0,2'd0,0,2'd0,3'd4,4'd0,0,0,2'd0));
      push(1, 1, 1, I_JAL, row(0,0,0,0,2'd0,0,2'd0,3'd4,4'd0,1,0,2'd0));
      push(1, 1, 1, I_JAL, row(0,0,0,1,2'd1,1,2'd2,3'd4,4'd0,1,0,2'd0));
      push(1, 1, 0, I_JALR, F_RDY);
      push(1, 1, 0, I_JALR, ZERO);
      push(1, 1, 0, I_JALR, row(0,0,0,0,2'd0,0,2'd0,3'd0,4'd0,1,0,2'd0));
      push(1, 1, 0, I_JALR, row(0,0,0,1,2'd2,1,2'd2,3'd0,4'd0,1,0,2'd0));
      push(1, 1, 0, I_LUI, F_RDY);
      push(1, 1, 0, I_LUI, row(0,0,0,0,2'd0,0,2'd0,3'd3,4'd0,0,0,2'd0));
      push(1, 1, 0, I_LUI, row(0,0,0,0,2'd0,0,2'd0,3'd3,4'd8,1,0,2'd0));
      push(1, 1, 0, I_LUI, row(0,0,0,1,2'd0,1,2'd0,3'd3,4'd8,1,0,2'd0));
      push(1, 1, 0, I_SW, F_RDY);
      push(1, 1, 0, I_SW, row(0,0,0,0,2'd0,0,2'd0,3'd1,4'd0,0,0,2'd0));
      push(1, 1, 0, I_SW, row(0,0,0,0,2'd0,0,2'd0,3'd1,4'd0,1,0,2'd0));
      push(1, 1, 0, I_SW, row(1,1,0,1,2'd0,0,2'd0,3'd1,4'd0,1,0,2'd0));
      push(1, 1, 0, I_SLLI_BAD, F_RDY);
      push(1, 1, 0, I_SLLI_BAD, ZERO);
      push(1, 1, 0, I_SLLI_BAD, row(0,0,0,0,2'd0,0,2'd0,3'd0,4'd0,0,1,2'd1));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s, obs); checks++;
         if (obs !== e) $display("FAIL back_to_back cyc%0d: got %05h expected %05h", k, obs, e);
         else passed++;
         k++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_lw_wait();
      test_illegal();
      test_timeout();
      test_timeout_race();
      test_sw_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
